// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions and FSM state types shared by the UART slice
package uart_pkg;
   localparam logic [1:0] UART_REG_CLK_DIV = 2'd0;
   localparam logic [1:0] UART_REG_STATUS  = 2'd1;
   localparam logic [1:0] UART_REG_DATA    = 2'd2;
   localparam int ST_TX_NOT_FULL  = 0;
   localparam int ST_RX_NOT_EMPTY = 1;
   localparam int ST_RX_OVERRUN   = 2;
   localparam int ST_RX_FRAME_ERR = 3;
   localparam int ST_TX_IDLE      = 4;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_buffered_if.sv
// uart_buffered_if: CPU peripheral bus between a master and the UART slave
interface uart_buffered_if;
   logic        sel_in;
   logic        read_in;
   logic [3:0]  write_mask_in;
   logic [31:0] address_in;
   logic [31:0] write_value_in;
   logic [31:0] read_value_out;
   modport master (output sel_in, read_in, write_mask_in, address_in, write_value_in, input read_value_out);
   modport slave (input sel_in, read_in, write_mask_in, address_in, write_value_in, output read_value_out);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular FIFO; push while full only lands alongside a pop
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;
   assign empty   = count == '0;
   assign full    = count == (AW+1)'(DEPTH);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];
   // storage write, no reset needed since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
   // pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/uart_buffered.sv
// uart_buffered: memory-mapped 8N1 UART with TX/RX FIFOs, bit divider and sticky RX error flags
module uart_buffered
   import uart_pkg::*;
#(
   parameter int                   TX_DEPTH    = 16,
   parameter int                   RX_DEPTH    = 16,
   parameter int                   DIV_WIDTH   = 16,
   parameter logic [DIV_WIDTH-1:0] RESET_DIV   = '0,
   parameter int                   SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_in,
   output logic             tx_out,
   uart_buffered_if.slave   bus
);
   logic [1:0]           reg_sel;
   logic                 wr_div, w1c, tx_push, rx_pop;
   logic [DIV_WIDTH-1:0] clk_div;
   logic [7:0]           tx_head, rx_head;
   logic                 tx_full, tx_empty, rx_full, rx_empty;
   tx_state_t            tx_state, tx_next;
   logic [DIV_WIDTH-1:0] tx_cnt;
   logic [2:0]           tx_bit;
   logic [7:0]           tx_shift;
   logic                 tx_tick, tx_pop, tx_idle;
   logic [SYNC_STAGES-1:0] rx_sync;
   logic                 rx_s, rx_prev;
   rx_state_t            rx_state, rx_next;
   logic [DIV_WIDTH-1:0] rx_cnt;
   logic [2:0]           rx_bit;
   logic [7:0]           rx_shift;
   logic                 rx_tick, rx_push, frame_set, overrun_set;
   logic                 overrun, frame_err;
   logic [31:0]          status;
   logic                 unused;
   assign unused  = ^{bus.address_in, bus.write_value_in};
   assign reg_sel = bus.address_in[3:2];
   assign wr_div  = bus.sel_in && reg_sel == UART_REG_CLK_DIV;
   assign w1c     = bus.sel_in && reg_sel == UART_REG_STATUS && bus.write_mask_in[0];
   assign tx_push = bus.sel_in && reg_sel == UART_REG_DATA && bus.write_mask_in[0];
   assign rx_pop  = bus.sel_in && bus.read_in && reg_sel == UART_REG_DATA;
   assign tx_tick = tx_cnt == '0;
   assign rx_tick = rx_cnt == '0;
   assign rx_s    = rx_sync[SYNC_STAGES-1];
   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) tx_fifo (
      .clk, .reset, .push(tx_push), .pop(tx_pop), .din(bus.write_value_in[7:0]),
      .head(tx_head), .full(tx_full), .empty(tx_empty)
   );
   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rx_fifo (
      .clk, .reset, .push(rx_push), .pop(rx_pop), .din(rx_shift),
      .head(rx_head), .full(rx_full), .empty(rx_empty)
   );
   // divider register, written byte lane by byte lane
   always_ff @(posedge clk) begin
      if (reset) clk_div <= RESET_DIV;
      else if (wr_div) begin
         for (int i = 0; i < DIV_WIDTH; i++)
            if (bus.write_mask_in[i/8]) clk_div[i] <= bus.write_value_in[i];
      end
   end
   // TX state, bit counter and shifter; counter reloads at every bit boundary
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
      end else begin
         tx_state <= tx_next;
         if (tx_pop) begin
            tx_shift <= tx_head;
            tx_cnt   <= clk_div;
         end else if (tx_state != TX_IDLE) begin
            tx_cnt <= tx_tick ? clk_div : tx_cnt - DIV_WIDTH'(1);
            if (tx_tick && tx_state == TX_DATA) begin
               tx_shift <= tx_shift >> 1;
               tx_bit   <= tx_bit + 3'd1;
            end
            if (tx_state == TX_START) tx_bit <= '0;
         end
      end
   end
   // TX next state; STOP chains straight into START when more bytes wait
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:  tx_next = tx_empty ? TX_IDLE : TX_START;
         TX_START: tx_next = tx_tick ? TX_DATA : TX_START;
         TX_DATA:  tx_next = tx_tick && tx_bit == 3'd7 ? TX_STOP : TX_DATA;
         TX_STOP:  tx_next = !tx_tick ? TX_STOP : tx_empty ? TX_IDLE : TX_START;
         default:  tx_next = TX_IDLE;
      endcase
   end
   // TX outputs; the FIFO pop coincides with entering START
   always_comb begin
      tx_pop  = tx_next == TX_START && tx_state != TX_START;
      tx_out  = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_shift[0] : 1'b1;
      tx_idle = tx_state == TX_IDLE && tx_empty;
   end
   // rx_in synchroniser plus previous sample for falling-edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync <= '1;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_in};
         rx_prev <= rx_s;
      end
   end
   // RX state, half-bit/full-bit counter and shifter
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_state <= rx_next;
         rx_cnt   <= rx_state == RX_IDLE ? clk_div >> 1 : rx_tick ? clk_div : rx_cnt - DIV_WIDTH'(1);
         if (rx_tick && rx_state == RX_DATA) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
         end
         if (rx_state == RX_START) rx_bit <= '0;
      end
   end
   // RX next state; a high line at the mid-start resample is treated as a glitch
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  rx_next = !rx_s && rx_prev ? RX_START : RX_IDLE;
         RX_START: rx_next = !rx_tick ? RX_START : rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  rx_next = rx_tick && rx_bit == 3'd7 ? RX_STOP : RX_DATA;
         RX_STOP:  rx_next = rx_tick ? RX_IDLE : RX_STOP;
         default:  rx_next = RX_IDLE;
      endcase
   end
   // RX outputs from the stop-bit sample
   always_comb begin
      rx_push     = rx_state == RX_STOP && rx_tick && rx_s;
      frame_set   = rx_state == RX_STOP && rx_tick && !rx_s;
      overrun_set = rx_push && rx_full && !rx_pop;
   end
   // sticky flags; a set in the same cycle as a W1C clear wins
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= overrun_set ? 1'b1 : w1c && bus.write_value_in[ST_RX_OVERRUN] ? 1'b0 : overrun;
         frame_err <= frame_set ? 1'b1 : w1c && bus.write_value_in[ST_RX_FRAME_ERR] ? 1'b0 : frame_err;
      end
   end
   // STATUS word assembly
   always_comb begin
      status                  = '0;
      status[ST_TX_NOT_FULL]  = !tx_full;
      status[ST_RX_NOT_EMPTY] = !rx_empty;
      status[ST_RX_OVERRUN]   = overrun;
      status[ST_RX_FRAME_ERR] = frame_err;
      status[ST_TX_IDLE]      = tx_idle;
   end
   assign bus.read_value_out = !bus.sel_in ? '0 :
                               reg_sel == UART_REG_CLK_DIV ? 32'(clk_div) :
                               reg_sel == UART_REG_STATUS ? status :
                               reg_sel == UART_REG_DATA ? {23'b0, !rx_empty, rx_empty ? 8'h00 : rx_head} : '0;
endmodule

// File: tb/tb_uart_buffered.sv
// tb_uart_buffered: directed stimulus with queued expectations checked by bus-read and TX-line monitors
module tb_uart_buffered;
   localparam logic [31:0] A_DIV = 32'h0, A_STAT = 32'h4, A_DATA = 32'h8, A_NONE = 32'hC;
   typedef struct {string name; logic [31:0] v;} rd_t;
   logic clk = 0, reset = 1, rx_in = 1, tx_out;
   int vectors = 0, miscompares = 0, tb_div = 0;
   bit tx_mon_en = 1, tx_cap = 0;
   rd_t rd_q[$];
   logic [7:0] tx_exp[$];
   uart_buffered_if bus();
   uart_buffered dut (.clk(clk), .reset(reset), .rx_in(rx_in), .tx_out(tx_out), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] m);
      bus.sel_in = 1; bus.read_in = 0; bus.address_in = a; bus.write_value_in = v; bus.write_mask_in = m;
      idle(1);
      bus.sel_in = 0; bus.write_mask_in = 0;
   endtask
   task automatic bus_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
      rd_q.push_back('{nm, exp});
      bus.sel_in = 1; bus.read_in = 1; bus.address_in = a; bus.write_mask_in = 0;
      idle(1);
      bus.sel_in = 0; bus.read_in = 0;
   endtask
   task automatic tx_byte(input logic [7:0] b, input bit expect_it);
      if (expect_it) tx_exp.push_back(b);
      bus_wr(A_DATA, {24'h0, b}, 4'b0001);
   endtask
   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin rx_in = f[i]; idle(tb_div + 1); end
      rx_in = 1;
   endtask
   task automatic wait_tx(input int limit);
      int k;
      k = 0;
      while ((tx_exp.size() != 0 || tx_cap) && k < limit) begin idle(1); k++; end
      chk("tx_drain_timeout", 32'(k >= limit), 0);
   endtask
   // bus read monitor
   initial begin
      rd_t r;
      forever begin
         @(negedge clk);
         if (bus.sel_in && bus.read_in) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
               r = rd_q.pop_front();
               chk(r.name, bus.read_value_out, r.v);
            end
         end
      end
   end
   // TX line monitor: decodes frames, checks bit hold time and back-to-back chaining
   initial begin
      logic [9:0] bits;
      logic [7:0] e;
      bit glitch, contig;
      int n;
      forever begin
         @(negedge clk);
         if (tx_mon_en && !reset && tx_out === 1'b0) begin
            contig = 1;
            while (contig) begin
               tx_cap = 1; n = tb_div + 1; glitch = 0;
               for (int i = 0; i < 10 * n; i++) begin
                  if (i > 0) @(negedge clk);
                  if (i % n == 0) bits[i/n] = tx_out;
                  else if (tx_out !== bits[i/n]) glitch = 1;
               end
               if (tx_exp.size() == 0) chk("tx_unexpected_frame", 32'(bits[8:1]), 32'hFFFF);
               else begin
                  e = tx_exp.pop_front();
                  chk("tx_start", 32'(bits[0]), 0);
                  chk("tx_byte", 32'(bits[8:1]), 32'(e));
                  chk("tx_stop", 32'(bits[9]), 1);
                  chk("tx_bit_hold", 32'(glitch), 0);
               end
               tx_cap = 0;
               contig = tx_exp.size() > 0;
               if (contig) begin
                  @(negedge clk);
                  chk("tx_gap", 32'(tx_out), 0);
                  contig = tx_out === 1'b0;
               end
            end
         end
      end
   end
   initial begin
      #500000;
      chk("watchdog", 1, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      bus.sel_in = 0; bus.read_in = 0; bus.write_mask_in = 0; bus.address_in = 0; bus.write_value_in = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_tx_out", 32'(tx_out), 1);
      @(posedge clk); #1;
      reset = 0;
      idle(1);
      bus_rd("reset_status", A_STAT, 32'h11);
      bus_rd("reset_div", A_DIV, 32'h0);
      bus_rd("empty_data", A_DATA, 32'h0);
      bus_rd("reg3", A_NONE, 32'h0);
      bus_wr(A_DIV, 32'hFFFF_1234, 4'b0010);
      bus_rd("div_lane1", A_DIV, 32'h1200);
      bus_wr(A_DIV, 32'h0000_0003, 4'b0011);
      bus_wr(A_NONE, 32'hFFFF_FFFF, 4'b1111);
      bus_rd("div_3", A_DIV, 32'h3);
      tb_div = 3;
      tx_byte(8'hA5, 1);
      wait_tx(200);
      bus_rd("tx_done_status", A_STAT, 32'h11);
      tx_byte(8'h01, 1);
      for (int k = 0; k < 17; k++) tx_byte(8'(8'h10 + k), k < 16);
      bus_rd("tx_full_status", A_STAT, 32'h00);
      wait_tx(1500);
      bus_rd("burst_done_status", A_STAT, 32'h11);
      bus_wr(A_DIV, 32'h7, 4'b0001);
      tb_div = 7;
      send_rx(8'h3C, 1);
      idle(8);
      bus_rd("rx_status", A_STAT, 32'h13);
      bus_rd("rx_data", A_DATA, 32'h13C);
      bus_rd("rx_data_after_pop", A_DATA, 32'h0);
      bus_rd("rx_status_empty", A_STAT, 32'h11);
      for (int k = 0; k < 17; k++) send_rx(8'(8'h40 + k), 1);
      idle(8);
      bus_rd("overrun_status", A_STAT, 32'h17);
      bus_wr(A_STAT, 32'h4, 4'b0001);
      bus_rd("overrun_cleared", A_STAT, 32'h13);
      for (int k = 0; k < 16; k++) bus_rd("overrun_data", A_DATA, 32'h100 | 32'(8'h40 + k));
      bus_rd("overrun_drained", A_DATA, 32'h0);
      send_rx(8'h55, 0);
      idle(16);
      bus_rd("frame_err_status", A_STAT, 32'h19);
      bus_rd("frame_err_data", A_DATA, 32'h0);
      bus_wr(A_STAT, 32'h4, 4'b0001);
      bus_rd("frame_err_kept", A_STAT, 32'h19);
      bus_wr(A_STAT, 32'h8, 4'b0001);
      bus_rd("frame_err_cleared", A_STAT, 32'h11);
      rx_in = 0; idle(1); rx_in = 1; idle(30);
      bus_rd("glitch_status", A_STAT, 32'h11);
      send_rx(8'h81, 1);
      idle(8);
      bus_rd("after_glitch_data", A_DATA, 32'h181);
      tx_mon_en = 0;
      tx_byte(8'h5A, 0);
      tx_byte(8'h77, 0);
      idle(20);
      reset = 1;
      @(posedge clk);
      @(negedge clk);
      chk("reset_mid_frame_tx_out", 32'(tx_out), 1);
      @(posedge clk); #1;
      reset = 0;
      idle(1);
      bus_rd("post_reset_status", A_STAT, 32'h11);
      bus_rd("post_reset_div", A_DIV, 32'h0);
      idle(20);
      @(negedge clk);
      chk("post_reset_tx_idle_line", 32'(tx_out), 1);
      idle(3);
      chk("rd_queue_drained", 32'(rd_q.size()), 0);
      chk("tx_queue_drained", 32'(tx_exp.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
